// File: rtl/qmf_synthesis_interp.sv
// ----------------------------------------------------------------------------
// qmf_synthesis_interp
//
// Two-channel QMF synthesis with built-in 2x interpolation. Each accepted
// low/high subband pair yields two full-band samples: the even phase
//   y[2m]   = sum_k h0[2k]   * (xl - xh)[m-k]
// followed by the odd phase
//   y[2m+1] = sum_k h0[2k+1] * (xl + xh)[m-k].
// A single multiply-accumulate unit is time-shared over P = NTAPS/2 taps per
// phase.
//
// Build option:
//   QMF_SYN_ROUND_EN  defined   -> output = sat((acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT)
//                     undefined -> output = sat(acc >>> OUT_SHIFT)
//
// Ports:
//   clk           clock
//   rstn          asynchronous active-low reset
//   clear_state   synchronous flush of history, accumulator and FSM
//   h0_coef_flat  prototype h0[n] at [n*COEFW +: COEFW], static while running
//   s_valid       subband pair valid
//   s_ready       block can accept a pair (high only in IDLE)
//   s_low         low-band sample (signed)
//   s_high        high-band sample (signed)
//   m_valid       full-band sample valid
//   m_ready       downstream accepts the sample
//   m_data        full-band sample (signed, saturated)
//   m_phase       0 = even output y[2m], 1 = odd output y[2m+1]
// ----------------------------------------------------------------------------
module qmf_synthesis_interp #(
    parameter int unsigned DATAW     = 16,
    parameter int unsigned COEFW     = 16,
    parameter int unsigned NTAPS     = 128,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear_state,
    input  logic [NTAPS*COEFW-1:0]   h0_coef_flat,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATAW-1:0]         s_low,
    input  logic [DATAW-1:0]         s_high,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATAW-1:0]         m_data,
    output logic                     m_phase
);

    localparam int unsigned P    = NTAPS / 2;
    localparam int unsigned KW   = $clog2(P);
    localparam int unsigned CW   = $clog2(NTAPS);
    localparam int unsigned HW   = DATAW + 1;          // exact width of sum/difference
    localparam int unsigned PW   = HW + COEFW;         // full-precision product width
    localparam int unsigned ACCW = DATAW + 1 + COEFW + $clog2(P);

    // Output clamp bounds expressed at the post-shift width (ACCW+1 bits).
    localparam logic signed [ACCW:0] SAT_MAX =
        {{(ACCW + 1 - DATAW){1'b0}}, {(DATAW - 1){1'b1}}};
    localparam logic signed [ACCW:0] SAT_MIN =
        {{(ACCW + 2 - DATAW){1'b1}}, {(DATAW - 1){1'b0}}};

`ifdef QMF_SYN_ROUND_EN
    // Half an output LSB; evaluates to zero when OUT_SHIFT is 0.
    localparam logic [ACCW:0] RND_OFS = ((ACCW + 1)'(1) << OUT_SHIFT) >> 1;
`else
    localparam logic [ACCW:0] RND_OFS = '0;
`endif

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StMac0  = 3'd1,
        StEmit0 = 3'd2,
        StMac1  = 3'd3,
        StEmit1 = 3'd4
    } state_e;

    state_e                  r_state;
    logic [KW-1:0]           r_k;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [HW-1:0]    r_dd [P];
    logic signed [HW-1:0]    r_ds [P];
    logic                    r_s_ready;
    logic                    r_m_valid;
    logic [DATAW-1:0]        r_m_data;
    logic                    r_m_phase;

    // ------------------------------------------------------------------
    // Coefficient unpack and MAC datapath
    // ------------------------------------------------------------------
    logic signed [COEFW-1:0] w_h0 [NTAPS];

    for (genvar n = 0; n < NTAPS; n++) begin : g_h0
        assign w_h0[n] = h0_coef_flat[n*COEFW +: COEFW];
    end

    logic                    w_odd;
    logic [CW-1:0]           w_cidx;
    logic signed [COEFW-1:0] w_coef;
    logic signed [HW-1:0]    w_hist;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACCW-1:0]  w_acc_next;

    // Coefficient index 2k (even phase) or 2k+1 (odd phase).
    assign w_odd      = (r_state == StMac1);
    assign w_cidx     = {r_k, w_odd};
    assign w_coef     = w_h0[w_cidx];
    assign w_hist     = w_odd ? r_ds[r_k] : r_dd[r_k];
    assign w_prod     = w_coef * w_hist;
    assign w_acc_next = r_acc + {{(ACCW - PW){w_prod[PW-1]}}, w_prod};

    // ------------------------------------------------------------------
    // New history entries: exact difference and sum of the subband pair
    // ------------------------------------------------------------------
    logic signed [HW-1:0] w_diff;
    logic signed [HW-1:0] w_sum;

    assign w_diff = {s_low[DATAW-1], s_low} - {s_high[DATAW-1], s_high};
    assign w_sum  = {s_low[DATAW-1], s_low} + {s_high[DATAW-1], s_high};

    // ------------------------------------------------------------------
    // Output scaling and saturation
    // ------------------------------------------------------------------
    logic signed [ACCW:0]  w_biased;
    logic signed [ACCW:0]  w_shifted;
    logic [DATAW-1:0]      w_sat;

    // One guard bit keeps the rounding add from wrapping.
    assign w_biased  = {r_acc[ACCW-1], r_acc} + RND_OFS;
    assign w_shifted = w_biased >>> OUT_SHIFT;

    always_comb begin
        w_sat = w_shifted[DATAW-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[DATAW-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[DATAW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= StIdle;
            r_k       <= '0;
            r_acc     <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_phase <= 1'b0;
            for (int i = 0; i < P; i++) begin
                r_dd[i] <= '0;
                r_ds[i] <= '0;
            end
        end else if (clear_state) begin
            // Flush wins over any handshake in the same cycle.
            r_state   <= StIdle;
            r_k       <= '0;
            r_acc     <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_phase <= 1'b0;
            for (int i = 0; i < P; i++) begin
                r_dd[i] <= '0;
                r_ds[i] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_s_ready <= 1'b1;
                    if (s_valid && r_s_ready) begin
                        for (int i = P - 1; i > 0; i--) begin
                            r_dd[i] <= r_dd[i-1];
                            r_ds[i] <= r_ds[i-1];
                        end
                        r_dd[0]   <= w_diff;
                        r_ds[0]   <= w_sum;
                        r_acc     <= '0;
                        r_k       <= '0;
                        r_s_ready <= 1'b0;
                        r_state   <= StMac0;
                    end
                end

                StMac0, StMac1: begin
                    r_acc <= w_acc_next;
                    if (r_k == KW'(P - 1)) begin
                        r_k     <= '0;
                        r_state <= (r_state == StMac0) ? StEmit0 : StEmit1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end

                StEmit0, StEmit1: begin
                    // First EMIT cycle registers the result; the sample then
                    // stays put until the downstream handshake.
                    if (!r_m_valid) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= w_sat;
                        r_m_phase <= (r_state == StEmit1);
                    end else if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_acc     <= '0;
                        if (r_state == StEmit0) begin
                            r_state <= StMac1;
                        end else begin
                            r_state   <= StIdle;
                            r_s_ready <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_phase = r_m_phase;

endmodule
